// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg: shared state encoding and read-buffer depth for the memory stream reader.
package mem_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if: command, memory read port and output stream of the reader.
interface mem_stream_reader_if #(parameter int AW = 4, parameter int DW = 4);
    logic          start;
    logic [AW-1:0] base;
    logic [AW-1:0] len_m1;
    logic          busy;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    modport master (
        input  start, base, len_m1, rd, out_ready,
        output busy, ra, out_valid, out_data, out_last
    );
    modport slave (
        output start, base, len_m1, rd, out_ready,
        input  busy, ra, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mem_rd_fifo.sv
// mem_rd_fifo: small read-data buffer; push and pop may coincide at any occupancy.
module mem_rd_fifo
    import mem_stream_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DW-1:0] m [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) m[i] <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) m[wp] <= din;
            if (push) wp <= nxt(wp);
            if (pop) rp <= nxt(rp);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign dout  = m[rp];
    assign full  = cnt == CW'(FIFO_DEPTH);
    assign empty = cnt == '0;
endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: streams a burst of words out of a registered-read memory
// with valid/ready backpressure and no data loss.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input logic clk,
    input logic rst_n,
    mem_stream_reader_if.master bus
);
    state_t        state;
    logic          pend;
    logic [AW-1:0] iss_left, len_q, out_cnt;
    logic          full, empty, pop, issue;
    logic [1:0]    occ;

    mem_rd_fifo #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pend),
        .din   (bus.rd),
        .pop   (pop),
        .dout  (bus.out_data),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid = !empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_last  = bus.out_valid && out_cnt == len_q;
    // A read may be issued when a word leaves this cycle, keeping 1 word/cycle under full flow.
    assign occ   = {1'b0, pend} + (full ? 2'd2 : {1'b0, !empty});
    assign issue = state == RUN && (occ < 2'd2 || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.ra   <= '0;
            pend     <= 1'b0;
            iss_left <= '0;
            len_q    <= '0;
            out_cnt  <= '0;
        end else begin
            pend <= issue;
            if (pop) out_cnt <= out_cnt + AW'(1);
            case (state)
                IDLE: if (bus.start) begin
                    state    <= RUN;
                    bus.busy <= 1'b1;
                    bus.ra   <= bus.base;
                    iss_left <= bus.len_m1;
                    len_q    <= bus.len_m1;
                    out_cnt  <= '0;
                end
                RUN: if (issue) begin
                    bus.ra <= bus.ra + AW'(1);
                    if (iss_left == '0) state <= DRAIN;
                    else iss_left <= iss_left - AW'(1);
                end
                DRAIN: if (pop && bus.out_last) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: directed burst vectors against a registered-read memory holding mem[i]=i.
module tb_mem_stream_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [3:0] mem [16];

    mem_stream_reader_if #(.AW(4), .DW(4)) bus ();
    mem_stream_reader #(.AW(4), .DW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) bus.rd <= mem[bus.ra];

    typedef struct {
        logic [3:0] b;
        logic [3:0] l;
        bit tog;
        bit mid;
        bit endst;
        int exp_words;
        int exp_lat;
        logic [3:0] exp_first;
        logic [3:0] exp_lastd;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s act=%0d want=%0d at %0t", n, act, want, $time);
        end
    endtask

    task automatic do_vec(input vec_t v);
        int k = 0;
        int lat = -1;
        bit stall = 0;
        bit done = 0;
        logic [3:0] held = '0;
        logic [3:0] fst = '0;
        logic [3:0] lst = '0;
        logic [3:0] ras [$];
        bus.start = 1'b1;
        bus.base = v.b;
        bus.len_m1 = v.l;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_rise", bus.busy, 1);
        for (int i = 0; i < 200 && !done; i++) begin
            if (v.mid && i == 3) begin
                bus.start = 1'b1;
                bus.base = 4'd9;
                bus.len_m1 = 4'd2;
            end
            if (v.mid && i == 4) bus.start = 1'b0;
            @(negedge clk);
            if (ras.size() == 0 || ras[ras.size()-1] != bus.ra) ras.push_back(bus.ra);
            if (stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, held);
            end
            stall = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            if (bus.out_valid && lat < 0) lat = i;
            if (bus.out_valid && bus.out_ready) begin
                if (k == 0) fst = bus.out_data;
                lst = bus.out_data;
                chk("data", bus.out_data, 4'(v.b + 4'(k)));
                chk("last", bus.out_last, k == int'(v.l));
                k++;
                if (bus.out_last) begin
                    done = 1;
                    if (v.endst) begin
                        bus.start = 1'b1;
                        bus.base = 4'd9;
                        bus.len_m1 = 4'd1;
                    end
                end
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.out_ready = v.tog ? !bus.out_ready : 1'b1;
        end
        if (!done) chk("timeout", 0, 1);
        chk("busy_fall", bus.busy, 0);
        chk("words", k, v.exp_words);
        chk("latency", lat, v.exp_lat);
        chk("first", fst, v.exp_first);
        chk("lastd", lst, v.exp_lastd);
        for (int j = 0; j < 4 && j <= int'(v.l); j++)
            chk("ra", (ras.size() > j) ? ras[j] : 4'hx, 4'(v.b + 4'(j)));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_valid", bus.out_valid, 0);
    endtask

    vec_t vecs [6];
    vec_t vrst;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        vecs[0] = '{4'd3,  4'd3,  0, 0, 0, 4,  2, 4'd3,  4'd6};
        vecs[1] = '{4'd14, 4'd3,  0, 0, 0, 4,  2, 4'd14, 4'd1};
        vecs[2] = '{4'd0,  4'd15, 1, 0, 0, 16, 2, 4'd0,  4'd15};
        vecs[3] = '{4'd3,  4'd3,  0, 1, 0, 4,  2, 4'd3,  4'd6};
        vecs[4] = '{4'd15, 4'd0,  0, 0, 1, 1,  2, 4'd15, 4'd15};
        vecs[5] = '{4'd7,  4'd15, 1, 0, 1, 16, 2, 4'd7,  4'd6};
        vrst    = '{4'd5,  4'd0,  0, 0, 0, 1,  2, 4'd5,  4'd5};
        bus.start = 1'b0;
        bus.base = '0;
        bus.len_m1 = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_ra", bus.ra, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) do_vec(vecs[i]);
        bus.start = 1'b1;
        bus.base = 4'd0;
        bus.len_m1 = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = bus.out_valid && bus.out_data == 4'd2;
            end
            if (!seen) chk("reset_wait", 0, 1);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_last", bus.out_last, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_ra", bus.ra, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stale_valid", bus.out_valid, 0);
        end
        do_vec(vrst);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
